bus_mem_loader: RTL and testbench
=================================

Name: bus_mem_loader

Overview:
- Parametrised program/data memory that sits on the stack core's shared bidirectional memory bus (mem_addr, mem_write, mem_data).
- Replaces hand-driven instruction words plus a standalone tristate buffer with a block that:
  - streams a program in over a valid/ready load port while holding the core in reset;
  - then releases the core and serves its reads and writes.
- Supports arbitrary data width, address width and depth, re-load without a global reset, and overflow detection.

Parameters:
- DATA_W, 16, bus and word width.
- ADDR_W, 11, core address width.
- DEPTH, 2048, number of implemented words (DEPTH <= 2**ADDR_W).
- LOAD_BASE, 0, first address written by the loader.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- mem_addr  input  ADDR_W  core address.
- mem_write  input  1  core write strobe; 1 = core drives mem_data.
- mem_data  inout  DATA_W  shared data bus.
- load_valid  input  1  loader word valid.
- load_data  input  DATA_W  loader word.
- load_last  input  1  marks final load word; qualified by load_valid.
- load_ready  output  1  block accepts a load word this cycle.
- load_start  input  1  request re-load (honoured in RUN only).
- core_rst  output  1  reset to the stack core.
- load_count  output  ADDR_W+1  words accepted in the current load.
- load_ovf  output  1  sticky overflow flag.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=LOAD, load_ptr=LOAD_BASE, load_count=0, load_ovf=0, core_rst=1.
  - load_ready=0 during the reset cycle; it rises the following cycle.
  - Memory contents are not cleared.
  - Reset mid-LOAD or mid-RUN behaves identically.
- States:
  - LOAD:
    - load_ready=1 and core_rst=1.
    - On a cycle with load_valid & load_ready: mem[load_ptr] <= load_data, load_ptr++, load_count++.
    - If load_last is also 1: next state RUN.
  - Overflow:
    - Accepting a word at load_ptr=DEPTH-1 with load_last=0 sets load_ovf=1.
    - The word is still written and state moves to RUN; there is no wrap.
  - RUN:
    - load_ready=0; load_valid is ignored.
    - core_rst is registered and falls one cycle after the LOAD->RUN transition edge.
  - RUN -> LOAD:
    - load_start=1 for one cycle returns to LOAD on the next edge.
    - On that edge: core_rst=1, load_ptr=LOAD_BASE, load_count=0.
    - load_ovf clears only on rst.
- Core reads (RUN only):
  - When mem_write=0, mem_data is driven with mem[mem_addr].
  - The read is combinational from mem_addr: same-cycle data, sampled by the core at the next edge.
  - mem_addr >= DEPTH reads as 0.
- Core writes (RUN only):
  - When mem_write=1, the block drives mem_data to Z.
  - mem[mem_addr] <= mem_data on the rising edge.
  - mem_addr >= DEPTH writes are dropped.
- Bus during LOAD: the block never drives mem_data (Z), and mem_write is ignored.
- Simultaneous events:
  - rst dominates everything.
  - load_start in LOAD is ignored.
  - load_last together with overflow: no ovf flag (the load ended legally at the last word).
- Arithmetic: load_count saturates at DEPTH; load_ptr is ADDR_W bits and never exceeds DEPTH-1.

Test Plan:
- Load 0x0FFF, 0x0000, 0x17FE (last on third):
  - load_count=3;
  - core_rst 1 through the accept edge of the third word, 0 one cycle later;
  - mem_addr=2, mem_write=0 -> mem_data=0x17FE.
- RUN write then read:
  - mem_addr=5, mem_write=1, bench drives 0xABCD -> block drives Z that cycle;
  - next cycle mem_write=0 -> mem_data=0xABCD.
- DEPTH=4, LOAD_BASE=0, load 5 words without last:
  - 4th word accepted -> load_ovf=1, state RUN;
  - 5th word not accepted (load_ready=0);
  - mem[3] holds the 4th word.
- Out-of-range access (DEPTH=1024):
  - read mem_addr=0x500 -> 0x0000;
  - write 0x1234 to 0x500 leaves mem[0x100] unchanged.
- load_start in RUN after program A (3 words), then load B (2 words, last):
  - core_rst high during reload;
  - mem[0..1]=B, mem[2]=A[2];
  - load_count=2.
- rst asserted mid-load after 1 word:
  - load_count=0, core_rst=1, load_ready=0 that cycle then 1;
  - next accepted word lands at LOAD_BASE.

Source files
------------

// File: rtl/bus_mem_loader.sv
// Program/data memory on the stack core's shared bus. Streams a program in over a
// valid/ready port while holding the core in reset, then serves core reads and writes.
module bus_mem_loader #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 11,
    parameter int DEPTH     = 2048,
    parameter int LOAD_BASE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_write,
    inout  wire  [DATA_W-1:0] mem_data,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              load_start,
    output logic              core_rst,
    output logic [ADDR_W:0]   load_count,
    output logic              load_ovf
);

    localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(LOAD_BASE);

    typedef enum logic {LOAD, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] load_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              accept;
    logic              in_range;
    logic              core_wr;
    logic [DATA_W-1:0] rd_data;

    assign accept   = (state == LOAD) && load_ready && load_valid;
    assign in_range = {1'b0, mem_addr} < DEPTH_C;
    assign core_wr  = (state == RUN) && mem_write && in_range;
    assign rd_data  = in_range ? mem[mem_addr[IDX_W-1:0]] : '0;

    // The bus is only ever driven for core reads in RUN; otherwise it floats.
    assign mem_data = ((state == RUN) && !mem_write) ? rd_data : {DATA_W{1'bz}};

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (accept) begin
                mem[load_ptr[IDX_W-1:0]] <= load_data;
            end else if (core_wr) begin
                mem[mem_addr[IDX_W-1:0]] <= mem_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            load_ptr   <= BASE_PTR;
            load_count <= '0;
            load_ovf   <= 1'b0;
            core_rst   <= 1'b1;
            load_ready <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    core_rst   <= 1'b1;
                    load_ready <= 1'b1;
                    if (accept) begin
                        if (load_count != DEPTH_C) begin
                            load_count <= load_count + 1'b1;
                        end
                        // The last implemented word ends the load either way; only an
                        // unterminated load at that point counts as an overflow.
                        if (load_last || (load_ptr == LAST_PTR)) begin
                            state      <= RUN;
                            load_ready <= 1'b0;
                            if (!load_last) begin
                                load_ovf <= 1'b1;
                            end
                        end else begin
                            load_ptr <= load_ptr + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (load_start) begin
                        state      <= LOAD;
                        core_rst   <= 1'b1;
                        load_ready <= 1'b1;
                        load_ptr   <= BASE_PTR;
                        load_count <= '0;
                    end else begin
                        core_rst <= 1'b0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_mem_loader.sv
// Directed plus randomized bench for bus_mem_loader: a 1024-word instance for load,
// bus and reload behaviour, and a 4-word instance for overflow.
module tb_bus_mem_loader;

    localparam int B_DEPTH = 1024;
    localparam int S_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          tests = 0;
    int          fails = 0;

    logic [10:0] mem_addr = '0;
    logic        mem_write = 1'b0;
    wire  [15:0] mem_data;
    logic        bus_en = 1'b0;
    logic [15:0] bus_drv = '0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        load_ready;
    logic        load_start = 1'b0;
    logic        core_rst;
    logic [11:0] load_count;
    logic        load_ovf;

    logic [10:0] s_mem_addr = '0;
    wire  [15:0] s_mem_data;
    logic        s_load_valid = 1'b0;
    logic [15:0] s_load_data = '0;
    logic        s_load_ready;
    logic        s_core_rst;
    logic [11:0] s_load_count;
    logic        s_load_ovf;

    logic [15:0] model_mem [B_DEPTH];
    bit          known [B_DEPTH];
    int          ptr_m = 0;
    int          cnt_m = 0;

    assign mem_data = bus_en ? bus_drv : 16'hzzzz;

    always #5 clk = ~clk;

    bus_mem_loader #(.DATA_W(16), .ADDR_W(11), .DEPTH(B_DEPTH), .LOAD_BASE(0)) u_big (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_write(mem_write),
        .mem_data(mem_data), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .load_start(load_start),
        .core_rst(core_rst), .load_count(load_count), .load_ovf(load_ovf)
    );

    bus_mem_loader #(.DATA_W(16), .ADDR_W(11), .DEPTH(S_DEPTH), .LOAD_BASE(0)) u_small (
        .clk(clk), .rst(rst), .mem_addr(s_mem_addr), .mem_write(1'b0),
        .mem_data(s_mem_data), .load_valid(s_load_valid), .load_data(s_load_data),
        .load_last(1'b0), .load_ready(s_load_ready), .load_start(1'b0),
        .core_rst(s_core_rst), .load_count(s_load_count), .load_ovf(s_load_ovf)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [15:0] d, input bit last);
        chk("load_ready_before_accept", {31'b0, load_ready}, 32'd1);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        cyc();
        load_valid = 1'b0;
        load_last  = 1'b0;
        model_mem[ptr_m] = d;
        known[ptr_m]     = 1'b1;
        ptr_m++;
        cnt_m++;
    endtask

    task automatic rd(input logic [10:0] a, input string tag);
        mem_addr  = a;
        mem_write = 1'b0;
        bus_en    = 1'b0;
        #1;
        if (int'(a) >= B_DEPTH) begin
            chk(tag, {16'b0, mem_data}, 32'd0);
        end else if (known[a]) begin
            chk(tag, {16'b0, mem_data}, {16'b0, model_mem[a]});
        end
    endtask

    task automatic wr(input logic [10:0] a, input logic [15:0] d);
        mem_addr  = a;
        mem_write = 1'b1;
        bus_en    = 1'b1;
        bus_drv   = d;
        #1;
        chk("write_bus_released", {16'b0, mem_data}, {16'b0, d});
        cyc();
        mem_write = 1'b0;
        bus_en    = 1'b0;
        if (int'(a) < B_DEPTH) begin
            model_mem[a] = d;
            known[a]     = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before the run completed");
        $fatal(1);
    end

    initial begin
        logic [15:0] b0, b1, w0, w1;
        logic [15:0] sw [5];
        logic [10:0] a;

        // Reset state
        cyc();
        chk("rst_load_ready", {31'b0, load_ready}, 32'd0);
        chk("rst_core_rst", {31'b0, core_rst}, 32'd1);
        chk("rst_load_count", {20'b0, load_count}, 32'd0);
        chk("rst_load_ovf", {31'b0, load_ovf}, 32'd0);
        rst = 1'b0;
        cyc();
        chk("ready_after_rst", {31'b0, load_ready}, 32'd1);

        // Program A
        load_word(16'h0FFF, 1'b0);
        load_word(16'h0000, 1'b0);
        chk("core_rst_mid_load", {31'b0, core_rst}, 32'd1);
        load_word(16'h17FE, 1'b1);
        chk("core_rst_at_last_edge", {31'b0, core_rst}, 32'd1);
        chk("count_after_A", {20'b0, load_count}, cnt_m);
        chk("ready_in_run", {31'b0, load_ready}, 32'd0);
        cyc();
        chk("core_rst_released", {31'b0, core_rst}, 32'd0);
        rd(11'd2, "read_A2");

        // Core write then read back
        wr(11'd5, 16'hABCD);
        rd(11'd5, "read_after_write");

        // Out-of-range accesses
        wr(11'h100, 16'h7777);
        rd(11'h500, "oor_read_zero");
        wr(11'h500, 16'h1234);
        rd(11'h100, "oor_write_dropped");

        // Randomized core traffic, keeping addresses 0..2 intact
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) a = 11'(B_DEPTH + $urandom_range(0, 1023));
            else a = 11'($urandom_range(3, 15));
            if ($urandom_range(0, 1) == 1) wr(a, 16'($urandom));
            else rd(a, "rand_read");
        end

        // Reload program B
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        chk("reload_core_rst", {31'b0, core_rst}, 32'd1);
        chk("reload_count_clear", {20'b0, load_count}, 32'd0);
        chk("reload_ready", {31'b0, load_ready}, 32'd1);
        ptr_m = 0;
        cnt_m = 0;
        mem_addr  = 11'd2;
        mem_write = 1'b1;
        bus_en    = 1'b1;
        bus_drv   = 16'h0000;
        load_start = 1'b1;
        #1;
        chk("load_bus_not_driven", {16'b0, mem_data}, 32'd0);
        cyc();
        load_start = 1'b0;
        mem_write  = 1'b0;
        bus_en     = 1'b0;
        chk("load_start_in_load_ignored", {20'b0, load_count}, 32'd0);
        b0 = 16'($urandom);
        b1 = 16'($urandom);
        load_word(b0, 1'b0);
        chk("reload_core_rst_held", {31'b0, core_rst}, 32'd1);
        load_word(b1, 1'b1);
        chk("count_after_B", {20'b0, load_count}, cnt_m);
        cyc();
        chk("reload_core_rst_released", {31'b0, core_rst}, 32'd0);
        rd(11'd0, "read_B0");
        rd(11'd1, "read_B1");
        rd(11'd2, "read_A2_kept");

        // Reset in the middle of a load
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        ptr_m = 0;
        cnt_m = 0;
        w0 = 16'($urandom);
        load_word(w0, 1'b0);
        chk("midload_count", {20'b0, load_count}, 32'd1);
        rst        = 1'b1;
        load_valid = 1'b1;
        load_data  = 16'hDEAD;
        cyc();
        rst        = 1'b0;
        load_valid = 1'b0;
        chk("midrst_count", {20'b0, load_count}, 32'd0);
        chk("midrst_core_rst", {31'b0, core_rst}, 32'd1);
        chk("midrst_ready_low", {31'b0, load_ready}, 32'd0);
        cyc();
        chk("midrst_ready_high", {31'b0, load_ready}, 32'd1);
        ptr_m = 0;
        cnt_m = 0;
        w1 = 16'($urandom);
        load_word(w1, 1'b1);
        cyc();
        rd(11'd0, "midrst_word_at_base");
        rd(11'd1, "midrst_dropped_word");

        // Overflow on the 4-word instance: five words, no last
        for (int i = 0; i < 5; i++) sw[i] = 16'($urandom);
        for (int i = 0; i < 5; i++) begin
            s_load_valid = 1'b1;
            s_load_data  = sw[i];
            #1;
            chk("ovf_ready", {31'b0, s_load_ready}, (i < S_DEPTH) ? 32'd1 : 32'd0);
            cyc();
            if (i == S_DEPTH - 1) begin
                chk("ovf_flag", {31'b0, s_load_ovf}, 32'd1);
                chk("ovf_count", {20'b0, s_load_count}, S_DEPTH);
            end
        end
        s_load_valid = 1'b0;
        chk("ovf_sticky", {31'b0, s_load_ovf}, 32'd1);
        chk("ovf_count_sat", {20'b0, s_load_count}, S_DEPTH);
        chk("ovf_core_released", {31'b0, s_core_rst}, 32'd0);
        s_mem_addr = 11'd3;
        #1;
        chk("ovf_mem3", {16'b0, s_mem_data}, {16'b0, sw[S_DEPTH-1]});
        s_mem_addr = 11'd0;
        #1;
        chk("ovf_mem0", {16'b0, s_mem_data}, {16'b0, sw[0]});
        s_mem_addr = 11'd4;
        #1;
        chk("ovf_oor_read", {16'b0, s_mem_data}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
